// File: rtl/iter_counter_pkg.sv
// ============================================================================
// iter_counter_pkg : shared state/mode definitions for iter_counter
// Rev 1.0
// ============================================================================
`default_nettype none

package iter_counter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/iter_counter.sv
// ============================================================================
// iter_counter : loadable down counter with start/done handshake,
//                one-shot / periodic modes, stall and abort
// Rev 1.0
// ============================================================================
`default_nettype none

module iter_counter
  import iter_counter_pkg::*;
#(
  parameter int MAX_COUNT = 32,
  localparam int W = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  input  logic         mode,
  input  logic         en,
  input  logic         abort,
  output logic [W-1:0] count,
  output logic         ready,
  output logic         busy,
  output logic         tick,
  output logic         done
);

  localparam logic [W-1:0] SAT_VAL = W'(MAX_COUNT);
  localparam logic [W-1:0] ONE     = W'(1);

  logic [0:0]   state;
  logic [W-1:0] reload;
  logic         mode_r;
  logic [W-1:0] w_cap;

  assign w_cap = (load_val > SAT_VAL) ? SAT_VAL : load_val;
  assign busy  = (state == ST_RUN);
  assign ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      reload <= '0;
      mode_r <= MODE_ONESHOT;
      tick   <= 1'b0;
      done   <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            reload <= w_cap;
            mode_r <= mode;
            count  <= w_cap;
            // A zero-iteration request completes immediately without going busy
            if (w_cap == '0) begin
              tick <= 1'b1;
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (en) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              tick <= 1'b1;
              if (mode_r == MODE_PERIODIC) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
